// File: rtl/jk_count_sequencer.sv
// Sequences an external bank of WIDTH JK flip-flops as a programmable modulo
// up/down counter with clear, parallel load, hold and run-length control.
module jk_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             up,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    input  logic [LEN_W-1:0] length,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [WIDTH-1:0] ld_reg, ld_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;

    logic [WIDTH-1:0] m_minus1;
    logic             above_mod;
    logic             wrap_up;
    logic             wrap_dn;
    logic             wrap;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] step_mask;
    logic             run_step;
    logic             in_clear;
    logic             in_load;

    // modulus 0 stands for 2^WIDTH: M-1 naturally becomes all ones, and no
    // feedback value can be at or above it.
    assign m_minus1  = modulus - WIDTH'(1);
    assign above_mod = (modulus != '0) && (q_fb >= modulus);
    assign wrap_up   = (q_fb >= m_minus1);
    assign wrap_dn   = (q_fb == '0) || above_mod;
    assign wrap      = up ? wrap_up : wrap_dn;

    always_comb begin
        if (up) begin
            next_val = wrap_up ? '0 : q_fb + WIDTH'(1);
        end else begin
            next_val = wrap_dn ? m_minus1 : q_fb - WIDTH'(1);
        end
    end

    assign step_mask = q_fb ^ next_val;
    assign run_step  = (state_reg == ST_RUN) && !stop;
    assign in_clear  = (state_reg == ST_CLEAR);
    assign in_load   = (state_reg == ST_LOAD);

    // Changing bits toggle (J=K=1); LOAD forces each bit with J=ld, K=~ld.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
        assign j[gi] = (in_load & ld_reg[gi]) | (run_step & step_mask[gi]);
        assign k[gi] = in_clear | (in_load & ~ld_reg[gi]) | (run_step & step_mask[gi]);
    end

    assign tc   = run_step && wrap;
    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        ld_next    = ld_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLEAR: state_next = ST_IDLE;
            ST_IDLE: begin
                if (load_en) begin
                    ld_next    = load_val;
                    state_next = ST_LOAD;
                end else if (start) begin
                    len_next   = length;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: state_next = ST_IDLE;
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + LEN_W'(1);
                    if ((len_reg != '0) && (cnt_reg == len_reg - LEN_W'(1))) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ld_reg    <= ld_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Bench for jk_count_sequencer driving a behavioural JK bank: directed vector
// table followed by random traffic, both checked against a spec-level model.
module tb_jk_count_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stop, up, load_en;
    logic [3:0] load_val, modulus;
    logic [7:0] length;
    logic [3:0] bank, j, k;
    logic       busy, tc, done;
    logic       preset_en;
    logic [3:0] preset_val;

    always #5 clk = ~clk;

    jk_count_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .up(up),
        .load_en(load_en), .load_val(load_val), .modulus(modulus),
        .length(length), .q_fb(bank), .j(j), .k(k),
        .busy(busy), .tc(tc), .done(done)
    );

    // JK bank: Q+ = J&~Q | ~K&Q per bit; preset only used at time zero
    always @(posedge clk) begin
        if (preset_en) bank <= preset_val;
        else           bank <= (j & ~bank) | (~k & bank);
    end

    localparam int M_CLEAR = 0, M_IDLE = 1, M_LOAD = 2, M_RUN = 3, M_DONE = 4;

    int         passed = 0;
    int         total  = 0;
    int         cyc    = 0;
    int         ms;
    logic [3:0] mq, mld;
    int         mlen, msteps;

    typedef struct {
        logic       rst, st, sp, u, le;
        logic [3:0] lv, m;
        logic [7:0] len;
        logic [3:0] eq;
        logic       etc, eb, ed;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic rst, st, sp, u, le, input logic [3:0] lv, m,
                       input logic [7:0] len, input logic [3:0] eq,
                       input logic etc, eb, ed);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.u = u; v.le = le;
        v.lv = lv; v.m = m; v.len = len; v.eq = eq;
        v.etc = etc; v.eb = eb; v.ed = ed;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Counting rule with M as a plain integer in 1..16
    function automatic logic [3:0] ref_next(input logic [3:0] q, input logic [3:0] m,
                                            input logic u, output logic wrap);
        int mm, qi, nx;
        mm = (m == 4'd0) ? 16 : int'(m);
        qi = int'(q);
        if (u) begin
            wrap = (qi >= mm - 1);
            nx   = wrap ? 0 : qi + 1;
        end else begin
            wrap = (qi == 0) || (qi >= mm);
            nx   = wrap ? mm - 1 : qi - 1;
        end
        return 4'(nx);
    endfunction

    task automatic cycle(input logic rst, st, sp, u, le, input logic [3:0] lv, m,
                         input logic [7:0] len);
        logic [3:0] ej, ek, nx;
        logic       eb, et, ed, wrap;
        int         ms_n;
        @(negedge clk);
        reset = rst; start = st; stop = sp; up = u; load_en = le;
        load_val = lv; modulus = m; length = len;
        #1;
        ej = 4'h0; ek = 4'h0; eb = 1'b1; et = 1'b0; ed = 1'b0; nx = mq; ms_n = ms;
        case (ms)
            M_CLEAR: begin ek = 4'hF; nx = 4'h0; ms_n = M_IDLE; end
            M_IDLE: begin
                eb = 1'b0;
                if (le) begin mld = lv; ms_n = M_LOAD; end
                else if (st) begin mlen = int'(len); msteps = 0; ms_n = M_RUN; end
            end
            M_LOAD: begin ej = mld; ek = ~mld; nx = mld; ms_n = M_IDLE; end
            M_RUN: begin
                if (sp) ms_n = M_IDLE;
                else begin
                    nx = ref_next(mq, m, u, wrap);
                    et = wrap;
                    ej = mq ^ nx; ek = mq ^ nx;
                    msteps++;
                    if (mlen != 0 && msteps == mlen) ms_n = M_DONE;
                end
            end
            default: begin ed = 1'b1; ms_n = M_IDLE; end
        endcase
        if (!rst) begin ms_n = M_CLEAR; msteps = 0; end
        $display("cyc %0d rst=%0b st=%0b sp=%0b up=%0b ld=%0b m=%0h q=%0h j=%0h k=%0h busy=%0b tc=%0b done=%0b",
                 cyc, rst, st, sp, u, le, m, bank, j, k, busy, tc, done);
        check("bank_q", bank, mq);
        check("j", j, ej);
        check("k", k, ek);
        check("busy", busy, eb);
        check("tc", tc, et);
        check("done", done, ed);
        ms = ms_n;
        mq = nx;
        cyc++;
    endtask

    initial begin
        logic [3:0] rm;
        reset = 1'b0; start = 1'b0; stop = 1'b0; up = 1'b0; load_en = 1'b0;
        load_val = 4'h0; modulus = 4'h0; length = 8'h0;
        preset_en = 1'b1; preset_val = 4'hB;
        mld = 4'h0; mlen = 0; msteps = 0;
        @(posedge clk);
        #1;
        preset_en = 1'b0;
        ms = M_CLEAR;
        mq = 4'hB;

        // reset held low for two edges, then release
        add(0,0,0,0,0, 4'h0, 4'd0, 8'd0, 4'hB, 0,1,0);
        add(1,0,0,0,0, 4'h0, 4'd0, 8'd0, 4'h0, 0,1,0);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h0, 0,0,0);
        // free-running M=10 up, stopped at 3
        add(1,1,0,1,0, 4'h0, 4'd10,8'd0, 4'h0, 0,0,0);
        for (int q = 0; q < 10; q++) add(1,0,0,1,0, 4'h0, 4'd10, 8'd0, 4'(q), (q == 9), 1, 0);
        for (int q = 0; q < 3; q++)  add(1,0,0,1,0, 4'h0, 4'd10, 8'd0, 4'(q), 0, 1, 0);
        add(1,0,1,1,0, 4'h0, 4'd10,8'd0, 4'h3, 0,1,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h3, 0,0,0);
        // load 3, count down five steps
        add(1,0,0,0,1, 4'h3, 4'd10,8'd0, 4'h3, 0,0,0);
        add(1,0,0,0,0, 4'h3, 4'd10,8'd0, 4'h3, 0,1,0);
        add(1,1,0,0,0, 4'h0, 4'd10,8'd5, 4'h3, 0,0,0);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h3, 0,1,0);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h2, 0,1,0);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h1, 0,1,0);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h0, 1,1,0);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h9, 0,1,0);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h8, 0,1,1);
        add(1,0,0,0,0, 4'h0, 4'd10,8'd0, 4'h8, 0,0,0);
        // out-of-range load C, one up step wraps to 0
        add(1,0,0,1,1, 4'hC, 4'd10,8'd0, 4'h8, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h8, 0,1,0);
        add(1,1,0,1,0, 4'h0, 4'd10,8'd1, 4'hC, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'hC, 1,1,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h0, 0,1,1);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h0, 0,0,0);
        // M=0 (full range) wraps at F
        add(1,0,0,1,1, 4'hF, 4'd0, 8'd0, 4'h0, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd0, 8'd0, 4'h0, 0,1,0);
        add(1,1,0,1,0, 4'h0, 4'd0, 8'd1, 4'hF, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd0, 8'd0, 4'hF, 1,1,0);
        add(1,0,0,1,0, 4'h0, 4'd0, 8'd0, 4'h0, 0,1,1);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h0, 0,0,0);
        // start with load_en: load wins
        add(1,1,0,1,1, 4'h5, 4'd10,8'd0, 4'h0, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h0, 0,1,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h5, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h5, 0,0,0);
        // stop on the final step of a length-2 run
        add(1,1,0,1,0, 4'h0, 4'd10,8'd2, 4'h5, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h5, 0,1,0);
        add(1,0,1,1,0, 4'h0, 4'd10,8'd0, 4'h6, 0,1,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h6, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h6, 0,0,0);
        // reset mid-run at q=5 with length 8
        add(1,0,0,1,1, 4'h4, 4'd10,8'd0, 4'h6, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h6, 0,1,0);
        add(1,1,0,1,0, 4'h0, 4'd10,8'd8, 4'h4, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h4, 0,1,0);
        add(0,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h5, 0,1,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h6, 0,1,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h0, 0,0,0);
        add(1,0,0,1,0, 4'h0, 4'd10,8'd0, 4'h0, 0,0,0);

        foreach (vt[i]) begin
            cycle(vt[i].rst, vt[i].st, vt[i].sp, vt[i].u, vt[i].le, vt[i].lv, vt[i].m, vt[i].len);
            check("tbl_q", bank, vt[i].eq);
            check("tbl_tc", tc, vt[i].etc);
            check("tbl_busy", busy, vt[i].eb);
            check("tbl_done", done, vt[i].ed);
        end

        // random traffic; modulus only changes while idle
        rm = 4'd10;
        for (int i = 0; i < 600; i++) begin
            if (ms == M_IDLE && $urandom_range(0, 3) == 0) rm = 4'($urandom);
            cycle($urandom_range(0, 59) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 14) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
                  4'($urandom), rm, 8'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
